// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - pops PS/2 receiver bytes, folds E0/F0 prefixes into key events
// and buffers them in a CPU-readable event FIFO with interrupt request.
module ps2_key_ctrl #(
   parameter int DEPTH  = 8,
   parameter int AW     = 3,
   parameter int SETTLE = 3
) (
   input  logic          clk_io,
   input  logic          reset,
   input  logic          ps2_ready,
   input  logic [7:0]    ps2_key,
   input  logic          ps2_overflow,
   output logic          ps2_rdn,
   input  logic          cpu_rd,
   input  logic          irq_en,
   output logic [15:0]   evt_data,
   output logic          evt_valid,
   output logic [AW:0]   evt_count,
   output logic          irq,
   output logic [7:0]    ovf_cnt
);

   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, POP, DECODE, WAIT} state_t;

   state_t        state, state_n;
   logic          rdy_m, rdy_s, ovf_m, ovf_s, ovf_d;
   logic [7:0]    byte_r;
   logic          ext_r, brk_r;
   logic [CW-1:0] cnt_r, cnt_n;
   logic          ld_byte, set_ext, set_brk, push;
   logic          do_push, do_pop;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_r;

   always_comb begin
      state_n = state;
      cnt_n   = cnt_r;
      ld_byte = 1'b0;
      set_ext = 1'b0;
      set_brk = 1'b0;
      push    = 1'b0;
      case (state)
         IDLE: begin
            // full event FIFO leaves bytes waiting in the receiver FIFO
            if (rdy_s && (count_r < FULL))
               state_n = POP;
         end
         POP: begin
            ld_byte = 1'b1;
            state_n = DECODE;
         end
         DECODE: begin
            if (byte_r == 8'hE0)
               set_ext = 1'b1;
            else if (byte_r == 8'hF0)
               set_brk = 1'b1;
            else
               push = 1'b1;
            cnt_n   = CW'(SETTLE);
            state_n = WAIT;
         end
         WAIT: begin
            cnt_n = cnt_r - 1'b1;
            if (cnt_r <= CW'(1))
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign do_push = push && (count_r != FULL);
   assign do_pop  = cpu_rd && (count_r != '0);

   always_ff @(posedge clk_io or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt_r   <= '0;
         ps2_rdn <= 1'b1;
         rdy_m   <= 1'b0;
         rdy_s   <= 1'b0;
         ovf_m   <= 1'b0;
         ovf_s   <= 1'b0;
         ovf_d   <= 1'b0;
         ovf_cnt <= 8'h00;
         byte_r  <= 8'h00;
         ext_r   <= 1'b0;
         brk_r   <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
      end else begin
         state   <= state_n;
         cnt_r   <= cnt_n;
         ps2_rdn <= (state_n != POP);
         rdy_m   <= ps2_ready;
         rdy_s   <= rdy_m;
         ovf_m   <= ps2_overflow;
         ovf_s   <= ovf_m;
         ovf_d   <= ovf_s;
         if (ovf_s && !ovf_d && (ovf_cnt != 8'hFF))
            ovf_cnt <= ovf_cnt + 8'h01;
         if (ld_byte)
            byte_r <= ps2_key;
         if (set_ext)
            ext_r <= 1'b1;
         if (set_brk)
            brk_r <= 1'b1;
         if (push) begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
         end
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count_r <= count_r + 1'b1;
         else if (!do_push && do_pop)
            count_r <= count_r - 1'b1;
      end
   end

   always_ff @(posedge clk_io) begin
      if (do_push)
         mem[wr_ptr] <= {ext_r, brk_r, 6'b0, byte_r};
   end

   assign evt_count = count_r;
   assign evt_valid = (count_r != '0);
   assign evt_data  = evt_valid ? mem[rd_ptr] : 16'h0000;
   assign irq       = evt_valid & irq_en;

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Controller that sequences the PS/2 receiver FIFO on behalf of the CPU.
- Pops raw bytes from the receiver FIFO using the ready/rdn handshake.
- Folds E0 (extended) and F0 (break) prefixes into complete 16-bit key events.
- Buffers events in a local FIFO that the CPU reads over the I/O bus, with an interrupt request.
- Sits between the ps2 receiver (clk_ps2 domain) and the CPU I/O decode (clk_io domain).

Parameters:
DEPTH, 8, event FIFO depth in entries (power of two).
AW, 3, event FIFO address width, log2(DEPTH).
SETTLE, 3, clk_io cycles waited after each pop before ps2_ready is sampled again.

Ports:
clk_io  in  1  I/O clock.
reset  in  1  asynchronous, active-high reset.
ps2_ready  in  1  receiver FIFO non-empty (clk_ps2 domain).
ps2_key  in  8  receiver FIFO head byte.
ps2_overflow  in  1  receiver FIFO overflow flag (clk_ps2 domain).
ps2_rdn  out  1  active-low pop strobe to the receiver FIFO.
cpu_rd  in  1  one-cycle pop request for the event FIFO.
irq_en  in  1  interrupt enable.
evt_data  out  16  head event: [15]=ext, [14]=brk, [13:8]=0, [7:0]=scan code.
evt_valid  out  1  event FIFO non-empty.
evt_count  out  AW+1  number of events held.
irq  out  1  evt_valid & irq_en (combinational from registered state).
ovf_cnt  out  8  saturating count of receiver overflow rising edges.

Behaviour:
- Synchronisers: ps2_ready and ps2_overflow each pass through a 2-flop synchroniser (rdy_s, ovf_s). ps2_key is captured only in POP; it is stable while ready is high.
- Reset values: ps2_rdn=1, state=IDLE, ext/brk flags=0, event FIFO empty (evt_count=0, evt_valid=0, evt_data=16'h0000, irq=0), ovf_cnt=0, synchronisers=0.
- FSM states are IDLE, POP, DECODE, WAIT.
  - IDLE: go to POP when rdy_s=1 and evt_count<DEPTH. When the event FIFO is full, stay in IDLE with ps2_rdn=1; backpressure is held in the receiver FIFO.
  - POP: ps2_rdn=0 for exactly this one cycle; latch ps2_key into byte_r. Go to DECODE.
  - DECODE, byte_r=8'hE0: ext<=1, no push.
  - DECODE, byte_r=8'hF0: brk<=1, no push.
  - DECODE, any other byte: push {ext,brk,6'b0,byte_r}, then clear ext and brk.
  - DECODE: load settle counter with SETTLE, go to WAIT.
  - WAIT: decrement the counter; go to IDLE in the cycle it reaches 0. WAIT lasts exactly SETTLE cycles.
- Latency: rdy_s high in IDLE at cycle N → ps2_rdn low at N+1 → push at N+2 → evt_valid high at N+3. Minimum byte spacing is 3+SETTLE cycles.
- Event FIFO:
  - evt_data shows the head when non-empty and reads 0 when empty.
  - cpu_rd with evt_count>0 pops the head. cpu_rd when empty is ignored; no underflow, pointers unchanged.
  - Push with count<DEPTH writes the entry. The FSM never pushes when full; the IDLE gate guarantees this.
  - Push and pop in the same cycle both take effect and evt_count is unchanged. This also applies when count=DEPTH with a pop: it cannot occur with a push, because of the IDLE gate.
  - Pointers are AW bits and wrap modulo DEPTH. evt_count is AW+1 bits, range 0..DEPTH.
- ovf_cnt increments on each rising edge of ovf_s and saturates at 8'hFF.
- Prefix handling:
  - Repeated E0 or F0 bytes leave the flag set.
  - The sequence F0 then E0 sets both flags.
  - No timeout on a pending prefix.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), ps2_rdn goes to 1 at once, and pending prefixes and buffered events are discarded.

Test Plan:
1. Receiver supplies 8'h1C → exactly one ps2_rdn low pulse; evt_data=16'h001C with evt_valid=1 three cycles after rdy_s; cpu_rd → evt_valid=0, evt_data=0.
2. Bytes F0,1C then E0,F0,75 → two pops without push for the prefixes; events 16'h401C then 16'hC075 in order; evt_count=2; irq=1 only while irq_en=1.
3. Nine non-prefix bytes 8'h01..8'h09 with no cpu_rd → evt_count=8, ps2_rdn stays 1 with ps2_ready high; one cpu_rd (head 16'h0001) → 9th byte popped, tail event 16'h0009, evt_count=8.
4. cpu_rd asserted in the same cycle as a DECODE push with evt_count=3 → evt_count stays 3, head advances by one; cpu_rd when empty → no change.
5. Three ps2_overflow pulses → ovf_cnt=3; 300 pulses → ovf_cnt=8'hFF.
6. Byte E0 popped, then reset pulsed during WAIT, then byte 1C → event 16'h001C (ext cleared), evt_count=1.
